// File: rtl/pwm_duty_meter_if.sv
// pwm_duty_meter bus: PWM input plus measurement results.
// The meter sits on the slave side; the PWM source/observer is the master.
interface pwm_duty_meter_if #(
    parameter int CNT_W = 32
);
    logic             pwm_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [2:0]       duty_code;
    logic             meas_valid;
    logic             timeout_flag;

    modport master (
        output pwm_in,
        input  period,
        input  high_time,
        input  duty_code,
        input  meas_valid,
        input  timeout_flag
    );

    modport slave (
        input  pwm_in,
        output period,
        output high_time,
        output duty_code,
        output meas_valid,
        output timeout_flag
    );
endinterface

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures PWM period/high time per rising edge,
// quantises duty to quarter steps and flags stuck-low/stuck-high.
module pwm_duty_meter #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    pwm_duty_meter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_STUCK_LO,
        ST_STUCK_HI
    } state_t;

    localparam int             XW    = CNT_W + 3;
    localparam logic [CNT_W-1:0] LP_TO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] r_hcnt;
    state_t           r_state;
    state_t           w_state_nxt;

    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic [2:0]       r_code;
    logic             r_valid;
    logic             r_flag;

    logic             w_rise;
    logic             w_at_to;
    logic             w_stuck;
    logic             w_ld_meas;
    logic             w_ld_stuck;

    logic [XW-1:0]    w_h8;
    logic [XW-1:0]    w_p1;
    logic [XW-1:0]    w_p3;
    logic [XW-1:0]    w_p5;
    logic [XW-1:0]    w_p7;
    logic [3:0]       w_ge;
    logic [2:0]       w_code;

    assign w_rise  = r_s2 & ~r_s3;
    assign w_at_to = (r_pcnt == LP_TO);
    assign w_stuck = (r_state == ST_STUCK_LO) ||
                     (r_state == ST_STUCK_HI);

    // Two-flop synchroniser plus a history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= bus.pwm_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Period/high counters: restart on rise, saturate at TIMEOUT, freeze when stuck
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= '0;
            r_hcnt <= '0;
        end else if (w_rise) begin
            r_pcnt <= LP_ONE;
            r_hcnt <= LP_ONE;
        end else if (!w_stuck && !w_at_to) begin
            r_pcnt <= r_pcnt + LP_ONE;
            r_hcnt <= r_hcnt + CNT_W'(r_s2);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and load strobes; a rise always beats a timeout
    always_comb begin
        w_state_nxt = r_state;
        w_ld_meas   = 1'b0;
        w_ld_stuck  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_MEASURE;
                end else if (w_at_to) begin
                    w_ld_stuck  = 1'b1;
                    w_state_nxt = r_s2 ? ST_STUCK_HI : ST_STUCK_LO;
                end
            end
            ST_MEASURE: begin
                if (w_rise) begin
                    w_ld_meas = 1'b1;
                end else if (w_at_to) begin
                    w_ld_stuck  = 1'b1;
                    w_state_nxt = r_s2 ? ST_STUCK_HI : ST_STUCK_LO;
                end
            end
            ST_STUCK_LO, ST_STUCK_HI: begin
                if (w_rise) begin
                    w_state_nxt = ST_MEASURE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Quarter-step quantiser: count thresholds 8h >= (2k+1)p, k = 0..3
    always_comb begin
        w_h8   = {r_hcnt, 3'b000};
        w_p1   = {3'b000, r_pcnt};
        w_p3   = w_p1 + (w_p1 << 1);
        w_p5   = w_p1 + (w_p1 << 2);
        w_p7   = (w_p1 << 3) - w_p1;
        w_ge   = {w_h8 >= w_p7, w_h8 >= w_p5,
                  w_h8 >= w_p3, w_h8 >= w_p1};
        w_code = {2'b00, w_ge[0]} + {2'b00, w_ge[1]} +
                 {2'b00, w_ge[2]} + {2'b00, w_ge[3]};
    end

    // Registered results, valid pulse and stuck flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= '0;
            r_high   <= '0;
            r_code   <= 3'd0;
            r_valid  <= 1'b0;
            r_flag   <= 1'b0;
        end else begin
            r_valid <= w_ld_meas | w_ld_stuck;
            if (w_ld_meas) begin
                r_period <= r_pcnt;
                r_high   <= r_hcnt;
                r_code   <= w_code;
                r_flag   <= 1'b0;
            end else if (w_ld_stuck) begin
                r_period <= LP_TO;
                r_high   <= r_s2 ? LP_TO : '0;
                r_code   <= r_s2 ? 3'd4 : 3'd0;
                r_flag   <= 1'b1;
            end else if (w_stuck && w_rise) begin
                r_flag   <= 1'b0;
            end
        end
    end

    assign bus.period       = r_period;
    assign bus.high_time    = r_high;
    assign bus.duty_code    = r_code;
    assign bus.meas_valid   = r_valid;
    assign bus.timeout_flag = r_flag;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb_pwm_duty_meter: directed + random PWM patterns checked every cycle
// against an edge-history reference model.
module tb_pwm_duty_meter;

    localparam int CNT_W = 32;
    localparam int TO    = 64;

    logic clk;
    logic rst_n;

    pwm_duty_meter_if #(.CNT_W(CNT_W)) bus ();

    pwm_duty_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // Model state: pwm samples since reset, last anchor cycle
    int hist[$];
    int anchor;
    bit armed;
    bit stuck;
    int e_period;
    int e_high;
    int e_code;
    int e_valid;
    int e_flag;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int s2_at(int m);
        if (m < 2) return 0;
        return hist[m-2];
    endfunction

    function automatic int quant(longint p, longint h);
        longint c;
        if (p <= 0) return 0;
        c = (8 * h + p) / (2 * p);
        if (c > 4) c = 4;
        return int'(c);
    endfunction

    task automatic model_reset();
        hist.delete();
        anchor   = 0;
        armed    = 0;
        stuck    = 0;
        e_period = 0;
        e_high   = 0;
        e_code   = 0;
        e_valid  = 0;
        e_flag   = 0;
    endtask

    // Expected outputs after the posedge that closes cycle m
    task automatic model_cycle();
        int m;
        int s2;
        int s3;
        int h;
        m  = hist.size() - 1;
        s2 = s2_at(m);
        s3 = s2_at(m - 1);
        e_valid = 0;
        if (s2 == 1 && s3 == 0) begin
            if (armed && !stuck) begin
                h = 0;
                for (int j = anchor; j < m; j++) h += s2_at(j);
                e_period = m - anchor;
                e_high   = h;
                e_code   = quant(m - anchor, h);
                e_valid  = 1;
            end
            anchor = m;
            armed  = 1;
            stuck  = 0;
            e_flag = 0;
        end else if (!stuck && (m - anchor) == TO) begin
            stuck    = 1;
            e_valid  = 1;
            e_flag   = 1;
            e_period = TO;
            e_high   = s2 ? TO : 0;
            e_code   = s2 ? 4 : 0;
        end
    endtask

    task automatic chk_all();
        chk("meas_valid", 32'(bus.meas_valid), e_valid);
        chk("timeout_flag", 32'(bus.timeout_flag), e_flag);
        chk("period", bus.period, e_period);
        chk("high_time", bus.high_time, e_high);
        chk("duty_code", 32'(bus.duty_code), e_code);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_period"}, bus.period, 0);
        chk({tag, "_high"}, bus.high_time, 0);
        chk({tag, "_code"}, 32'(bus.duty_code), 0);
        chk({tag, "_valid"}, 32'(bus.meas_valid), 0);
        chk({tag, "_flag"}, 32'(bus.timeout_flag), 0);
    endtask

    task automatic drive(bit v);
        @(negedge clk);
        bus.pwm_in = v;
        @(posedge clk);
        hist.push_back(int'(v));
        model_cycle();
        #1;
        chk_all();
    endtask

    task automatic pat(int hi, int lo, int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) drive(1'b1);
            for (int i = 0; i < lo; i++) drive(1'b0);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int p;
        int h;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.pwm_in = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        release_reset();

        // 25 %, then 50 % and 75 %
        pat(1, 3, 5);
        chk("p25_period", bus.period, 4);
        chk("p25_high", bus.high_time, 1);
        chk("p25_code", 32'(bus.duty_code), 1);
        pat(2, 2, 4);
        chk("p50_code", 32'(bus.duty_code), 2);
        pat(3, 1, 4);
        chk("p75_code", 32'(bus.duty_code), 3);

        // Rounding on period 8
        pat(1, 7, 3);
        chk("r8h1_code", 32'(bus.duty_code), 1);
        pat(3, 5, 3);
        chk("r8h3_code", 32'(bus.duty_code), 2);
        pat(7, 1, 3);
        chk("r8h7_code", 32'(bus.duty_code), 4);

        // Stuck low, then recover with 1/3
        pat(0, 80, 1);
        chk("slo_flag", 32'(bus.timeout_flag), 1);
        chk("slo_period", bus.period, TO);
        pat(1, 3, 4);
        chk("slo_rec_code", 32'(bus.duty_code), 1);

        // Stuck high, then recover with 2/2
        pat(80, 0, 1);
        chk("shi_high", bus.high_time, TO);
        chk("shi_code", 32'(bus.duty_code), 4);
        pat(2, 2, 4);
        chk("shi_rec_code", 32'(bus.duty_code), 2);

        // Rise coinciding with pcnt == TIMEOUT
        pat(1, 63, 3);
        chk("p64_period", bus.period, TO);

        // Random periods, some long enough to time out
        for (int i = 0; i < 30; i++) begin
            p = int'($urandom_range(2, 72));
            h = int'($urandom_range(1, p - 1));
            pat(h, p - h, 1 + int'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-period
        pat(2, 2, 3);
        drive(1'b1);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        bus.pwm_in = 1'b0;
        #1;
        chk_zero("midrst");
        repeat (3) begin
            @(negedge clk);
            bus.pwm_in = ~bus.pwm_in;
        end
        release_reset();
        pat(2, 2, 4);
        chk("post_rst_code", 32'(bus.duty_code), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_duty_meter.md
# pwm_duty_meter

- Downstream monitor for the PWM stage: samples a PWM waveform and measures period and high time in clock cycles on every rising edge.
- Quantises the measurement to the nearest quarter-step duty code, 0 = 0 % through 4 = 100 %.
- Detects stuck-low and stuck-high outputs by timeout, so self-test logic can confirm the PWM stage's 0/25/50/75/100 % sequence.

## Interface
- CNT_W, 32: width of the period and high-time counters and outputs.
- TIMEOUT, 64: number of cycles without a rising edge before a stuck condition is declared. Must satisfy 4 ≤ TIMEOUT < 2^CNT_W.
- clk, input, 1: single clock. Everything is sampled on posedge.
- rst_n, input, 1: reset, asynchronous, active-low.
- pwm_in, input, 1: PWM waveform under measurement. May be asynchronous to clk.
- period, output, CNT_W: last measured period in cycles, or TIMEOUT when stuck.
- high_time, output, CNT_W: synchronised-high cycles in the last period. On timeout it is TIMEOUT if stuck high, 0 if stuck low.
- duty_code, output, 3: quantised duty, 0..4. Values 5..7 are never driven.
- meas_valid, output, 1: one-cycle pulse when period, high_time and duty_code update.
- timeout_flag, output, 1: high while in a stuck state.

## Operation
- **Synchroniser:** two flops, s1 then s2. A third flop s3 holds the previous s2. Rising edge rise = s2 & ~s3.
- **Counters:** pcnt counts cycles since the last rise. hcnt counts cycles with s2 = 1 in the same window. Both are CNT_W wide.
- **Counter on rise:** pcnt loads 1, and hcnt loads 1 because s2 = 1 on the rise cycle.
- **Counter otherwise:** pcnt += 1 and hcnt += s2.
- **Counter range:** pcnt never exceeds TIMEOUT, so no wrap is possible.
- **State machine:** IDLE, MEASURE, STUCK_LOW, STUCK_HIGH. Reset enters IDLE.
- **IDLE:** rise → MEASURE with no meas_valid, because the first period is incomplete. pcnt reaching TIMEOUT → stuck state chosen by s2.
- **MEASURE, on rise:** latch period = pcnt and high_time = hcnt, compute duty_code, pulse meas_valid. Stay in MEASURE.
- **MEASURE, timeout:** when pcnt == TIMEOUT with no rise that cycle, go to STUCK_HIGH if s2 = 1, else STUCK_LOW.
- **Entering a stuck state:** drive period = TIMEOUT, high_time = TIMEOUT or 0, duty_code = 4 or 0. Pulse meas_valid once and set timeout_flag.
- **STUCK_LOW / STUCK_HIGH:** hold outputs with no further meas_valid. Counters freeze.
- **Leaving a stuck state:** rise → MEASURE, clear timeout_flag, restart the counters, no meas_valid. STUCK_HIGH needs a fall then a rise.
- **Simultaneous rise and pcnt == TIMEOUT:** rise wins; measure normally with period = TIMEOUT.
- **Duty quantisation (no divider):** duty_code = count of k in {0,1,2,3} with 8·high ≥ (2k+1)·period.
  - Compare in CNT_W+3 bits.
  - A tie rounds up, e.g. 12.5 % → 1 and 37.5 % → 2.
  - Implemented as four parallel comparators plus an adder.
- **Reset (async assert, sync release):**
  - Outputs: period = 0, high_time = 0, duty_code = 0, meas_valid = 0, timeout_flag = 0.
  - Internal: s1/s2/s3 = 0, pcnt = hcnt = 0, state IDLE.
  - Reset mid-period discards the partial measurement.

## Timing
- All outputs are registered.
- **Measurement latency:** pwm_in rises before posedge N, so s2 = 1 after N+1. rise is evaluated in cycle N+2. meas_valid, period, high_time and duty_code are visible after posedge N+2 and held through N+3; meas_valid is high for exactly that one cycle.
- **Timeout latency:** meas_valid and timeout_flag rise one cycle after the cycle in which pcnt == TIMEOUT.
- **Minimum period:** 2 cycles measurable (1 high, 1 low). Shorter pulses may be lost in the synchroniser.
- **Throughput:** one measurement per PWM period. Outputs hold until the next update.

## Test plan
- 25 % pattern: 1 high, 3 low, repeated. From the second rise onward, period = 4, high_time = 1, duty_code = 1, meas_valid once per 4 cycles. No valid on the first rise.
- 50 % and 75 % patterns: 2/2 → period 4, high 2, code 2. 3/1 → period 4, high 3, code 3. Check the code changes on the first full period after a pattern switch.
- Rounding: period 8 with high 1 → code 1 (tie). High 3 → code 2. High 7 → code 4. Period 8 with high 0 is impossible; cover low-only via the timeout.
- Stuck low: hold pwm_in = 0 for over 64 cycles after MEASURE → single meas_valid, period 64, high 0, code 0, timeout_flag = 1. The next 1/3 pattern clears the flag and gives code 1 after one full period.
- Stuck high: hold pwm_in = 1 → code 4, high_time 64, timeout_flag = 1. Returning to a 2/2 pattern → flag cleared on the first rise, code 2 on the following rise.
- Reset mid-period: assert rst_n = 0 asynchronously with pwm_in toggling → all outputs 0 immediately. After release, no meas_valid until the second rise.
